// File: rtl/fifo_drain_reader_if.sv
// fifo_drain_reader_if: valid/ready byte stream carried out of the drain reader
interface fifo_drain_reader_if #(
  parameter int DW = 8
);
  logic m_valid;
  logic [DW-1:0] m_data;
  logic m_ready;
  modport master (output m_valid, m_data, input m_ready);
  modport slave (input m_valid, m_data, output m_ready);
endinterface

// File: rtl/fifo_drain_reader.sv
// fifo_drain_reader: drains a synchronous FIFO through a skid buffer onto a valid/ready stream
module fifo_drain_reader #(
  parameter int DW = 8,
  parameter int OBUF_DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic fifo_rd,
  input  logic fifo_empty,
  input  logic fifo_wr,
  input  logic [DW-1:0] fifo_dout,
  fifo_drain_reader_if.master m,
  output logic [CNT_W-1:0] words_out,
  output logic busy
);
  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int OW = $clog2(OBUF_DEPTH + 1);
  localparam logic [OW:0] DEPTH = (OW + 1)'(OBUF_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(OBUF_DEPTH - 1);
  logic [DW-1:0] mem [OBUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic pend, acc, pop;
  // reads are gated on local room (occupancy plus in-flight word) only, never on m_ready
  always_comb begin
    fifo_rd = !rst && en && !fifo_empty && ({1'b0, occ} + {{OW{1'b0}}, pend}) < DEPTH;
    acc = fifo_rd && !fifo_empty && !fifo_wr;
    m.m_valid = occ != '0;
    m.m_data = m.m_valid ? mem[rd_ptr] : '0;
    pop = m.m_valid && m.m_ready;
    busy = pend || m.m_valid;
  end
  // skid storage captures the word that arrives one cycle after an accepted read; left unreset
  always_ff @(posedge clk)
    if (pend) mem[wr_ptr] <= fifo_dout;
  // in-flight flag, circular pointers, occupancy and delivered-word counter
  always_ff @(posedge clk)
    if (rst) begin
      pend <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      words_out <= '0;
    end else begin
      pend <= acc;
      if (pend) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      occ <= occ + OW'(pend) - OW'(pop);
      if (pop) words_out <= words_out + 1'b1;
    end
endmodule

// File: tb/tb_fifo_drain_reader.sv
// tb_fifo_drain_reader: directed stimulus against a FIFO model and a queue-based reference of the reader
module tb_fifo_drain_reader;
  typedef struct {
    logic [7:0] d;
    int t;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic fifo_wr = 1'b0;
  logic [7:0] fifo_din = 8'h00;
  logic fifo_clr = 1'b0;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic rdy = 1'b1;
  logic fifo_rd, fifo_rd4, busy, busy4;
  logic [15:0] words_out;
  logic [3:0] words_out4;
  logic [7:0] fq[$];
  ent_t mq[$];
  int e = 0;
  int dcnt = 0;
  int npass = 0;
  int ntot = 0;

  fifo_drain_reader_if #(.DW(8)) s ();
  fifo_drain_reader_if #(.DW(8)) s4 ();
  assign s.m_ready = rdy;
  assign s4.m_ready = rdy;

  fifo_drain_reader #(.DW(8), .OBUF_DEPTH(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_rd(fifo_rd), .fifo_empty(fifo_empty),
    .fifo_wr(fifo_wr), .fifo_dout(fifo_dout), .m(s), .words_out(words_out), .busy(busy)
  );
  fifo_drain_reader #(.DW(8), .OBUF_DEPTH(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .fifo_rd(fifo_rd4), .fifo_empty(fifo_empty),
    .fifo_wr(fifo_wr), .fifo_dout(fifo_dout), .m(s4), .words_out(words_out4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at edge %0d", nm, got, exp, e);
    else npass++;
  endtask

  // FIFO environment: write priority, registered one-cycle read data
  initial forever begin
    @(posedge clk);
    if (fifo_clr) fq.delete();
    else if (fifo_wr) fq.push_back(fifo_din);
    else if (fifo_rd && fq.size() != 0) fifo_dout <= fq.pop_front();
    fifo_empty <= fq.size() == 0;
  end

  // reference: each accepted word becomes visible two edges later and leaves in order on handshake
  initial begin
    bit exp_rd, exp_v;
    logic [7:0] exp_d;
    ent_t x;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e++;
      exp_rd = !rst && en && fq.size() != 0 && mq.size() < 3;
      exp_v = mq.size() != 0 && mq[0].t <= e;
      exp_d = exp_v ? mq[0].d : 8'h00;
      chk("cyc_rd", fifo_rd, exp_rd);
      chk("cyc_valid", s.m_valid, exp_v);
      chk("cyc_data", s.m_data, exp_d);
      chk("cyc_words", words_out, dcnt % 65536);
      chk("cyc_words4", words_out4, dcnt % 16);
      chk("cyc_busy", busy, mq.size() != 0);
      chk("cyc_data4", s4.m_data, exp_d);
      if (rst) begin
        mq.delete();
        dcnt = 0;
      end else begin
        if (exp_v && rdy) begin
          void'(mq.pop_front());
          dcnt++;
        end
        if (exp_rd && !fifo_wr) begin
          x.d = fq[0];
          x.t = e + 2;
          mq.push_back(x);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [7:0] d);
    fifo_wr = 1'b1;
    fifo_din = d;
    cyc();
    fifo_wr = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = mq.size() == 0 && fq.size() == 0;
    end
    ntot++;
    if (!done) $display("FAIL wait_idle got=busy exp=idle within 300 cycles");
    else npass++;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bit [6:0] er = 7'b0001111;
    bit [6:0] ev = 7'b0111100;
    byte unsigned ed[7] = '{8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00};
    // reset with FIFO holding data and en high
    cyc();
    wr_word(8'h55);
    wr_word(8'h56);
    repeat (2) begin
      @(negedge clk);
      chk("rst_rd", fifo_rd, 0);
      cyc();
    end
    rst = 1'b0;
    en = 1'b0;
    @(negedge clk);
    chk("rst_valid", s.m_valid, 0);
    chk("rst_data", s.m_data, 0);
    chk("rst_words", words_out, 0);
    chk("rst_busy", busy, 0);
    cyc();
    rst = 1'b1;
    fifo_clr = 1'b1;
    cyc();
    rst = 1'b0;
    fifo_clr = 1'b0;
    // streaming
    for (int i = 0; i < 4; i++) wr_word(8'h11 + 8'(i));
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("str_rd", fifo_rd, er[k]);
      chk("str_valid", s.m_valid, ev[k]);
      chk("str_data", s.m_data, ed[k]);
    end
    chk("str_words", words_out, 4);
    chk("str_busy", busy, 0);
    cyc();
    // backpressure
    en = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) wr_word(8'hB0 + 8'(i));
    en = 1'b1;
    repeat (6) cyc();
    @(negedge clk);
    chk("bp_rd", fifo_rd, 0);
    chk("bp_valid", s.m_valid, 1);
    chk("bp_data", s.m_data, 8'hB0);
    chk("bp_left", fq.size(), 2);
    cyc();
    rdy = 1'b1;
    wait_idle();
    @(negedge clk);
    chk("bp_words", words_out, 9);
    cyc();
    // write contention
    en = 1'b0;
    fifo_wr = 1'b1;
    fifo_din = 8'hA0;
    cyc();
    en = 1'b1;
    fifo_din = 8'hA1;
    @(negedge clk);
    chk("wc_rd0", fifo_rd, 1);
    cyc();
    fifo_din = 8'hA2;
    @(negedge clk);
    chk("wc_rd1", fifo_rd, 1);
    chk("wc_busy1", busy, 0);
    cyc();
    fifo_wr = 1'b0;
    @(negedge clk);
    chk("wc_busy2", busy, 0);
    wait_idle();
    @(negedge clk);
    chk("wc_words", words_out, 12);
    cyc();
    // enable drop, then reset with two words buffered
    en = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) wr_word(8'hC0 + 8'(i));
    en = 1'b1;
    @(negedge clk);
    chk("en_rd", fifo_rd, 1);
    cyc();
    en = 1'b0;
    @(negedge clk);
    chk("en_off_rd", fifo_rd, 0);
    chk("en_busy", busy, 1);
    cyc();
    cyc();
    @(negedge clk);
    chk("en_valid", s.m_valid, 1);
    chk("en_data", s.m_data, 8'hC0);
    chk("en_left", fq.size(), 2);
    cyc();
    en = 1'b1;
    cyc();
    en = 1'b0;
    cyc();
    @(negedge clk);
    chk("en_busy2", busy, 1);
    cyc();
    rst = 1'b1;
    fifo_clr = 1'b1;
    cyc();
    rst = 1'b0;
    fifo_clr = 1'b0;
    @(negedge clk);
    chk("mrst_valid", s.m_valid, 0);
    chk("mrst_words", words_out, 0);
    chk("mrst_busy", busy, 0);
    cyc();
    // counter wrap on the 4-bit instance
    rdy = 1'b1;
    for (int i = 0; i < 17; i++) wr_word(8'(i * 3 + 1));
    en = 1'b1;
    wait_idle();
    @(negedge clk);
    chk("wrap_words", words_out, 17);
    chk("wrap_words4", words_out4, 1);
    cyc();
    // interleaved stalls while streaming
    en = 1'b0;
    for (int i = 0; i < 8; i++) wr_word(8'hE0 + 8'(i));
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rdy = (i % 3) != 0;
      cyc();
    end
    rdy = 1'b1;
    wait_idle();
    @(negedge clk);
    chk("mix_words", words_out, 25);
    chk("mix_words4", words_out4, 9);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/fifo_drain_reader.md
Name: fifo_drain_reader

Overview:
Read-side master for the team's 8-bit synchronous FIFO. It drives the FIFO's rd strobe and watches empty. It captures dout, which has one cycle of read latency, and re-presents the data as a valid/ready stream to a downstream consumer. A small output skid buffer sustains one word per cycle through the read latency with no combinational ready-to-rd path. It also counts delivered words for status.

Parameters:
DW, 8, data width; matches the FIFO din/dout width.
OBUF_DEPTH, 3, output skid buffer entries; minimum 2; 3 or more gives full throughput.
CNT_W, 16, width of the delivered-word counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
en  in  1  enable; when low, no new FIFO reads are issued.
fifo_rd  out  1  read strobe to the FIFO.
fifo_empty  in  1  FIFO empty flag.
fifo_wr  in  1  tap of the FIFO write strobe; the FIFO gives write priority, so this decides whether a read is accepted.
fifo_dout  in  DW  FIFO registered read data.
m_valid  out  1  stream data valid.
m_data  out  DW  stream data.
m_ready  in  1  downstream ready.
words_out  out  CNT_W  count of words delivered (valid and ready handshakes), wraps.
busy  out  1  high while a read is in flight or the buffer holds data.

Behaviour:
- Reset (rst=1 at an edge): occ=0, pend=0, words_out=0, buffer pointers=0. While rst=1, fifo_rd is forced to 0. After reset: m_valid=0, m_data=0, busy=0.
- Buffer storage is not reset. m_data is forced to 0 whenever m_valid=0.
- fifo_rd (combinational) = !rst && en && !fifo_empty && (occ + pend) < OBUF_DEPTH. It must not depend on m_ready.
- Read acceptance at edge N: acc = fifo_rd && !fifo_empty && !fifo_wr.
  - When fifo_wr=1, the FIFO ignores rd. In that case pend is not set and fifo_rd may stay asserted.
- pend <= acc. The word appears on fifo_dout after edge N.
- If pend=1 at edge N+1, fifo_dout is pushed into the buffer. m_valid rises after edge N+1, so latency from accepted rd to m_valid is 2 edges.
- Buffer is a circular array with wr_ptr, rd_ptr and occ (0..OBUF_DEPTH). Pointers wrap modulo OBUF_DEPTH.
  - m_valid = (occ != 0); m_data = entry at rd_ptr.
  - pop = m_valid && m_ready.
  - Simultaneous push and pop: occ unchanged, both pointers advance.
  - The fifo_rd gating guarantees a push never happens while occ = OBUF_DEPTH.
- Stream rule: once m_valid=1, m_valid and m_data hold until pop. Data leaves in FIFO read order with no loss or duplication.
- words_out increments by 1 on each pop and wraps modulo 2^CNT_W.
- busy = pend || (occ != 0).
- en deassert: new reads stop immediately. An in-flight read is still captured, and the buffer keeps draining.
- FIFO empty mid-stream: fifo_rd drops and the buffer drains. Reading resumes the cycle after empty falls.
- rst mid-operation: the pending read and buffered words are discarded. The system resets the FIFO on the same rst.
- Steady state with OBUF_DEPTH=3, m_ready=1, no writes, FIFO non-empty: one accepted read and one pop per cycle.

Test Plan:
- Reset: assert rst 2 cycles with FIFO non-empty and en=1 -> fifo_rd=0 throughout; afterwards m_valid=0, m_data=0, words_out=0, busy=0.
- Streaming: preload FIFO with 0x11,0x12,0x13,0x14; en=1, m_ready=1 -> fifo_rd high 4 cycles; m_valid first high 2 edges after first accepted rd; m_data 0x11..0x14 on 4 consecutive cycles; words_out=4; busy=0 after.
- Backpressure: 5 words in FIFO, m_ready=0 -> exactly 3 reads accepted, then fifo_rd=0 with occ=3 and m_data=first word held. Raise m_ready -> all 5 words delivered in order, words_out=5.
- Write contention: FIFO holds 0xA0; hold fifo_wr=1 for 2 cycles writing 0xA1,0xA2 while fifo_rd=1 -> no pend during those cycles. Output order is 0xA0,0xA1,0xA2, each exactly once.
- Enable/reset mid-stream: drop en the cycle after an accepted read -> that word still appears on m_data and no further reads occur. Then assert rst with occ=2 -> m_valid=0 next cycle and words_out=0.
- Counter wrap (CNT_W=4): deliver 17 words -> words_out=1.
